// File: rtl/pulse_dispatch_pkg.sv
// Shared types and field helpers for the pulse dispatcher.
// Holds the channel FSM encoding, cfg field positions and command word layout.
package pulse_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } chan_state_t;

    localparam int CFG_SEL_LSB     = 0;
    localparam int DEF_ENV_START_W = 12;
    localparam int DEF_ENV_LEN_W   = 12;
    localparam int DEF_AMP_WIDTH   = 16;
    localparam int DEF_FREQ_WIDTH  = 9;
    localparam int DEF_PHASE_WIDTH = 17;
    localparam int DEF_MODE_W      = 2;

    // Command layout, MSB first: env start, env length, amp, freq, phase, mode.
    typedef struct packed {
        logic [DEF_ENV_START_W-1:0] env_start;
        logic [DEF_ENV_LEN_W-1:0]   env_len;
        logic [DEF_AMP_WIDTH-1:0]   amp;
        logic [DEF_FREQ_WIDTH-1:0]  freq;
        logic [DEF_PHASE_WIDTH-1:0] phase;
        logic [DEF_MODE_W-1:0]      mode;
    } cmd_t;

    function automatic int cfg_mode_lsb(input int sel_w);
        return sel_w;
    endfunction

    function automatic int cmd_width(input int es, input int el, input int amp,
                                     input int freq, input int ph, input int mode);
        return es + el + amp + freq + ph + mode;
    endfunction

endpackage

// File: rtl/pulse_dispatch_chan.sv
// One element channel: command FIFO plus issue FSM with an ARM timeout.
// A command issues only from IDLE with the element free; fields hold between strobes.
module pulse_dispatch_chan
    import pulse_dispatch_pkg::*;
#(
    parameter int CMD_W      = 68,
    parameter int FIFO_DEPTH = 4,
    parameter int ARM_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [CMD_W-1:0]            push_dat,
    input  logic                        busy,
    output logic                        cmdstb,
    output logic [CMD_W-1:0]            cmd_dat,
    output logic                        idle,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int CNT_W = $clog2(ARM_CYCLES) + 1;

    chan_state_t      state;
    logic [CNT_W-1:0] arm_cnt;
    logic [CMD_W-1:0] head;
    logic             pop;

    assign pop  = (state == ST_IDLE) & ~empty & ~busy & ~flush;
    assign idle = (state == ST_IDLE);

    sync_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cmdstb  <= 1'b0;
            cmd_dat <= '0;
            arm_cnt <= '0;
        end else begin
            cmdstb <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pop) begin
                            cmd_dat <= head;
                            cmdstb  <= 1'b1;
                            arm_cnt <= '0;
                            state   <= ST_ARM;
                        end
                    end
                    // An element that never raises busy is treated as a zero-length pulse.
                    ST_ARM: begin
                        if (busy) begin
                            state <= ST_WAIT;
                        end else if (arm_cnt == CNT_W'(ARM_CYCLES - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            arm_cnt <= arm_cnt + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!busy) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: registered occupancy, combinational head read.
// Pushes while full and pops while empty are ignored; clr empties it in one cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign pop_dat = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pulse_dispatch.sv
// Routes processor pulse commands into per-element queues and gates the end-of-program strobe.
// Issue latency two cycles when idle; busy elements back-pressure into their queue, full-queue pushes drop.
module pulse_dispatch
    import pulse_dispatch_pkg::*;
#(
    parameter int N_ELEM      = 3,
    parameter int SEL_W       = 2,
    parameter int MODE_W      = DEF_MODE_W,
    parameter int ENV_START_W = DEF_ENV_START_W,
    parameter int ENV_LEN_W   = DEF_ENV_LEN_W,
    parameter int AMP_WIDTH   = DEF_AMP_WIDTH,
    parameter int FREQ_WIDTH  = DEF_FREQ_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int ARM_CYCLES  = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_stb,
    input  logic [SEL_W+MODE_W-1:0]                       in_cfg,
    input  logic [ENV_START_W+ENV_LEN_W-1:0]              in_env,
    input  logic [AMP_WIDTH-1:0]                          in_amp,
    input  logic [FREQ_WIDTH-1:0]                         in_freq,
    input  logic [PHASE_WIDTH-1:0]                        in_phase,
    input  logic                                          in_preset,
    input  logic                                          proc_done,
    input  logic [N_ELEM-1:0]                             elem_busy,
    output logic [N_ELEM-1:0]                             elem_cmdstb,
    output logic [N_ELEM*ENV_START_W-1:0]                 elem_envstart,
    output logic [N_ELEM*ENV_LEN_W-1:0]                   elem_envlength,
    output logic [N_ELEM*AMP_WIDTH-1:0]                   elem_amp,
    output logic [N_ELEM*FREQ_WIDTH-1:0]                  elem_freq,
    output logic [N_ELEM*PHASE_WIDTH-1:0]                 elem_phase,
    output logic [N_ELEM*MODE_W-1:0]                      elem_mode,
    output logic [N_ELEM-1:0]                             elem_reset,
    output logic [N_ELEM*($clog2(FIFO_DEPTH)+1)-1:0]      fifo_level,
    output logic [N_ELEM-1:0]                             overflow,
    output logic                                          bad_sel,
    output logic                                          stbend,
    output logic                                          nobusy
);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int MODE_LSB = cfg_mode_lsb(SEL_W);
    localparam int CMD_W    = cmd_width(ENV_START_W, ENV_LEN_W, AMP_WIDTH,
                                        FREQ_WIDTH, PHASE_WIDTH, MODE_W);
    localparam int P_MODE   = 0;
    localparam int P_PHASE  = P_MODE + MODE_W;
    localparam int P_FREQ   = P_PHASE + PHASE_WIDTH;
    localparam int P_AMP    = P_FREQ + FREQ_WIDTH;
    localparam int P_LEN    = P_AMP + AMP_WIDTH;
    localparam int P_START  = P_LEN + ENV_LEN_W;
    localparam logic [SEL_W:0] N_ELEM_V = (SEL_W+1)'(N_ELEM);

    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic              stb_live;
    logic [CMD_W-1:0]  cmd_in;
    logic [N_ELEM-1:0] push_req;
    logic [N_ELEM-1:0] full;
    logic [N_ELEM-1:0] empty;
    logic [N_ELEM-1:0] idle;
    logic [CMD_W-1:0]  cmd_q [N_ELEM];

    // A preset cycle discards any strobe arriving alongside it.
    assign stb_live = in_stb & ~in_preset;
    assign sel      = in_cfg[CFG_SEL_LSB +: SEL_W];
    assign sel_ok   = ({1'b0, sel} < N_ELEM_V);
    assign cmd_in   = {in_env[0 +: ENV_START_W],
                       in_env[ENV_START_W +: ENV_LEN_W],
                       in_amp, in_freq, in_phase,
                       in_cfg[MODE_LSB +: MODE_W]};

    for (genvar k = 0; k < N_ELEM; k++) begin : g_chan
        assign push_req[k] = stb_live & sel_ok & (sel == SEL_W'(k));

        pulse_dispatch_chan #(
            .CMD_W      (CMD_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .ARM_CYCLES (ARM_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (reset),
            .flush    (in_preset),
            .push     (push_req[k]),
            .push_dat (cmd_in),
            .busy     (elem_busy[k]),
            .cmdstb   (elem_cmdstb[k]),
            .cmd_dat  (cmd_q[k]),
            .idle     (idle[k]),
            .empty    (empty[k]),
            .full     (full[k]),
            .level    (fifo_level[k*LVL_W +: LVL_W])
        );

        assign elem_envstart[k*ENV_START_W +: ENV_START_W] = cmd_q[k][P_START +: ENV_START_W];
        assign elem_envlength[k*ENV_LEN_W +: ENV_LEN_W]    = cmd_q[k][P_LEN +: ENV_LEN_W];
        assign elem_amp[k*AMP_WIDTH +: AMP_WIDTH]          = cmd_q[k][P_AMP +: AMP_WIDTH];
        assign elem_freq[k*FREQ_WIDTH +: FREQ_WIDTH]       = cmd_q[k][P_FREQ +: FREQ_WIDTH];
        assign elem_phase[k*PHASE_WIDTH +: PHASE_WIDTH]    = cmd_q[k][P_PHASE +: PHASE_WIDTH];
        assign elem_mode[k*MODE_W +: MODE_W]               = cmd_q[k][P_MODE +: MODE_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= '0;
            bad_sel    <= 1'b0;
            elem_reset <= '0;
            nobusy     <= 1'b0;
            stbend     <= 1'b0;
        end else begin
            overflow   <= overflow | (push_req & full);
            bad_sel    <= bad_sel | (stb_live & ~sel_ok);
            elem_reset <= {N_ELEM{in_preset}};
            nobusy     <= ~|elem_busy;
            stbend     <= proc_done & (&empty) & (&idle) & ~|elem_busy;
        end
    end

endmodule
